// File: rtl/flappy_pkg.sv
// Shared constants for the Flappy Bird VGA game: 640x480@60 timing, colours,
// reset positions and pipe geometry.
package flappy_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [9:0] BIRD_X      = 10'd160;
    localparam logic [9:0] BIRD_Y_RST  = 10'd232;
    localparam logic [9:0] PIPE_X_RST  = 10'd640;
    localparam logic [9:0] PIPE_W      = 10'd48;
    localparam logic [9:0] PIPE_SPEED  = 10'd2;
    localparam logic [9:0] GAP_Y_RST   = 10'd176;
    localparam logic [9:0] GAP_BASE    = 10'd64;
    localparam logic [9:0] GRAVITY     = 10'd2;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK = 6'b00_00_00;
    localparam rgb_t COL_BIRD  = 6'b11_11_00;
    localparam rgb_t COL_PIPE  = 6'b00_11_00;
    localparam rgb_t COL_SKY   = 6'b00_10_11;
    localparam rgb_t COL_OVER  = 6'b11_00_00;

    typedef enum logic {
        ST_PLAY,
        ST_OVER
    } game_state_t;

    // Fibonacci LFSR with taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/flappy_bird_vga_timing.sv
// 640x480@60 pixel/line counters with active-low sync generation.
module vga_timing
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       visible
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (h_count == H_LAST) begin
            h_count <= 10'd0;
            v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    assign hsync   = !((h_count >= H_SYNC_START) && (h_count <= H_SYNC_END));
    assign vsync   = !((v_count >= V_SYNC_START) && (v_count <= V_SYNC_END));
    assign visible = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);

endmodule

// File: rtl/tt_um_flappy_bird.sv
// Flappy Bird game top: per-frame game update and registered VGA pixel mux.
// Optional build macro FLAPPY_GRAVITY_EN pulls an idle bird downwards.
module tt_um_flappy_bird
    import flappy_pkg::*;
#(
    parameter int BIRD_SIZE = 16,
    parameter int GAP_H     = 128,
    parameter int STEP      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [9:0] BIRD_SZ    = 10'(BIRD_SIZE);
    localparam logic [9:0] GAP        = 10'(GAP_H);
    localparam logic [9:0] STEP_PX    = 10'(STEP);
    localparam logic [9:0] BIRD_Y_MAX = 10'(480 - BIRD_SIZE);

    logic [9:0]  h_count, v_count;
    logic        hsync, vsync, visible;
    logic        frame_tick;
    logic        up, down, restart;
    logic        unused;

    game_state_t state, state_n;
    logic [9:0]  bird_y, bird_y_n;
    logic [9:0]  pipe_x, pipe_x_n;
    logic [9:0]  gap_y, gap_y_n;
    logic [7:0]  lfsr, lfsr_n;
    logic [7:0]  score, score_n;
    logic [9:0]  pipe_right, pipe_right_n;
    logic        hit;
    logic        game_over;
    logic        in_bird, in_pipe;
    rgb_t        colour;

    vga_timing u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_count (h_count),
        .v_count (v_count),
        .hsync   (hsync),
        .vsync   (vsync),
        .visible (visible)
    );

    assign unused     = &{1'b0, ena, uio_in, ui_in[7:3]};
    assign up         = ui_in[0];
    assign down       = ui_in[1];
    assign restart    = ui_in[2];
    assign frame_tick = (h_count == 10'd0) && (v_count == V_VISIBLE);
    assign game_over  = (state == ST_OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_PLAY;
            bird_y <= BIRD_Y_RST;
            pipe_x <= PIPE_X_RST;
            gap_y  <= GAP_Y_RST;
            lfsr   <= LFSR_SEED;
            score  <= 8'd0;
        end else begin
            state  <= state_n;
            bird_y <= bird_y_n;
            pipe_x <= pipe_x_n;
            gap_y  <= gap_y_n;
            lfsr   <= lfsr_n;
            score  <= score_n;
        end
    end

    // Collision is judged on the positions produced by this same update
    always_comb begin
        state_n      = state;
        bird_y_n     = bird_y;
        pipe_x_n     = pipe_x;
        gap_y_n      = gap_y;
        lfsr_n       = lfsr;
        score_n      = score;
        pipe_right   = pipe_x + PIPE_W;
        pipe_right_n = pipe_right;
        hit          = 1'b0;
        if (frame_tick) begin
            if (restart) begin
                state_n  = ST_PLAY;
                bird_y_n = BIRD_Y_RST;
                pipe_x_n = PIPE_X_RST;
                gap_y_n  = GAP_Y_RST;
                lfsr_n   = LFSR_SEED;
                score_n  = 8'd0;
            end else begin
                lfsr_n = lfsr_next(lfsr);
                if (state == ST_PLAY) begin
                    if (up && !down) begin
                        bird_y_n = (bird_y < STEP_PX) ? 10'd0 : bird_y - STEP_PX;
                    end else if (down && !up) begin
                        bird_y_n = (bird_y > BIRD_Y_MAX - STEP_PX) ? BIRD_Y_MAX : bird_y + STEP_PX;
                    end
`ifdef FLAPPY_GRAVITY_EN
                    else begin
                        bird_y_n = (bird_y > BIRD_Y_MAX - GRAVITY) ? BIRD_Y_MAX : bird_y + GRAVITY;
                    end
`endif
                    if (pipe_x < PIPE_SPEED) begin
                        pipe_x_n = PIPE_X_RST;
                        gap_y_n  = GAP_BASE + {2'b00, lfsr};
                    end else begin
                        pipe_x_n = pipe_x - PIPE_SPEED;
                    end
                    pipe_right_n = pipe_x_n + PIPE_W;
                    if ((pipe_right >= BIRD_X) && (pipe_right_n < BIRD_X)) begin
                        score_n = score + 8'd1;
                    end
                    hit = (pipe_x_n < BIRD_X + BIRD_SZ) && (pipe_right_n > BIRD_X) &&
                          ((bird_y_n < gap_y_n) || (bird_y_n + BIRD_SZ > gap_y_n + GAP));
                    if (hit) begin
                        state_n = ST_OVER;
                    end
                end
            end
        end
    end

    assign in_bird = (h_count >= BIRD_X) && (h_count < BIRD_X + BIRD_SZ) &&
                     (v_count >= bird_y) && (v_count < bird_y + BIRD_SZ);
    assign in_pipe = (h_count >= pipe_x) && (h_count < pipe_x + PIPE_W) &&
                     ((v_count < gap_y) || (v_count >= gap_y + GAP));

    always_comb begin
        colour = COL_BLACK;
        if (visible) begin
            if (in_bird) begin
                colour = COL_BIRD;
            end else if (in_pipe) begin
                colour = COL_PIPE;
            end else if (game_over) begin
                colour = COL_OVER;
            end else begin
                colour = COL_SKY;
            end
        end
    end

    // Syncs go through the same register as colour so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out <= 8'h88;
        end else begin
            uo_out <= {hsync, colour.b[0], colour.g[0], colour.r[0],
                       vsync, colour.b[1], colour.g[1], colour.r[1]};
        end
    end

    assign uio_out = score;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_flappy_bird.sv
// Self-checking bench for tt_um_flappy_bird: VGA timing, directed game scenarios
// and randomized button presses compared against a frame-level game model.
`timescale 1ns/1ps
module tb_tt_um_flappy_bird;

    localparam int BIRD_SIZE = 16;
    localparam int GAP_H     = 128;
    localparam int STEP      = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    int m_bird, m_pipe, m_gap, m_lfsr, m_score;
    bit m_over;

    tt_um_flappy_bird #(
        .BIRD_SIZE (BIRD_SIZE),
        .GAP_H     (GAP_H),
        .STEP      (STEP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_bird  = 232;
        m_pipe  = 640;
        m_gap   = 176;
        m_lfsr  = 8'hA5;
        m_score = 0;
        m_over  = 1'b0;
    endtask

    // One game frame described directly from the game rules
    task automatic modelFrame(input logic [7:0] ui);
        logic [7:0] l;
        int         fb, old_right, next_lfsr;
        if (ui[2]) begin
            modelReset();
            return;
        end
        l = m_lfsr[7:0];
        fb = int'(^(l & 8'hB8));
        next_lfsr = ((m_lfsr * 2) % 256) + fb;
        if (!m_over) begin
            old_right = m_pipe + 48;
            if (ui[0] && !ui[1]) m_bird = (m_bird - STEP < 0) ? 0 : m_bird - STEP;
            else if (ui[1] && !ui[0]) m_bird = (m_bird + STEP > 480 - BIRD_SIZE) ? 480 - BIRD_SIZE : m_bird + STEP;
`ifdef FLAPPY_GRAVITY_EN
            else m_bird = (m_bird + 2 > 480 - BIRD_SIZE) ? 480 - BIRD_SIZE : m_bird + 2;
`endif
            if (m_pipe < 2) begin
                m_pipe = 640;
                m_gap  = 64 + m_lfsr;
            end else begin
                m_pipe = m_pipe - 2;
            end
            if (old_right >= 160 && m_pipe + 48 < 160) m_score = (m_score + 1) % 256;
            if (m_pipe < 160 + BIRD_SIZE && m_pipe + 48 > 160 &&
                (m_bird < m_gap || m_bird + BIRD_SIZE > m_gap + GAP_H)) m_over = 1'b1;
        end
        m_lfsr = next_lfsr;
    endtask

    function automatic logic [7:0] expectedPixel(input int x, input int y);
        logic [1:0] r, g, b;
        logic       hs, vs;
        hs = !(x >= 656 && x < 752);
        vs = !(y >= 490 && y < 492);
        {r, g, b} = 6'd0;
        if (x < 640 && y < 480) begin
            if (x >= 160 && x < 160 + BIRD_SIZE && y >= m_bird && y < m_bird + BIRD_SIZE) {r, g, b} = {2'd3, 2'd3, 2'd0};
            else if (x >= m_pipe && x < m_pipe + 48 && (y < m_gap || y >= m_gap + GAP_H)) {r, g, b} = {2'd0, 2'd3, 2'd0};
            else if (m_over) {r, g, b} = {2'd3, 2'd0, 2'd0};
            else {r, g, b} = {2'd0, 2'd2, 2'd3};
        end
        return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    endfunction

    // Forcing the frame strobe runs one game update per clock instead of per frame
    task automatic applyStimulus(input logic [7:0] ui, input int frames);
        @(negedge clk);
        ui_in = ui;
        force dut.frame_tick = 1'b1;
        repeat (frames) @(posedge clk);
        #1;
        release dut.frame_tick;
        for (int i = 0; i < frames; i++) modelFrame(ui);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_bird"}, 32'(dut.bird_y), 32'(m_bird));
        checkOutput({tag, "_pipe"}, 32'(dut.pipe_x), 32'(m_pipe));
        checkOutput({tag, "_gap"}, 32'(dut.gap_y), 32'(m_gap));
        checkOutput({tag, "_lfsr"}, 32'(dut.lfsr), 32'(m_lfsr));
        checkOutput({tag, "_score"}, 32'(uio_out), 32'(m_score));
        checkOutput({tag, "_over"}, 32'(dut.game_over), 32'(m_over));
    endtask

    task automatic waitBit(input int idx, input logic level, input int budget,
                           output longint t, output bit ok);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (uo_out[idx] === level) begin
                ok = 1'b1;
                t = cyc;
            end
        end
    endtask

    task automatic checkPixel(input int x, input int y, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 420000 && !found; i++) begin
            @(negedge clk);
            if (dut.h_count == 10'(x) && dut.v_count == 10'(y)) found = 1'b1;
        end
        checkOutput({tag, "_reached"}, 32'(found), 32'd1);
        if (found) begin
            @(posedge clk);
            #1;
            checkOutput(tag, 32'(uo_out), 32'(expectedPixel(x, y)));
        end
    endtask

    initial begin
        longint  t0, t1, t2;
        bit      ok0, ok1, ok2;
        bit      hit_row;
        logic [7:0] ui;

        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_uo", 32'(uo_out), 32'h88);
        checkOutput("rst_h", 32'(dut.h_count), 32'd0);
        checkOutput("rst_v", 32'(dut.v_count), 32'd0);
        checkOutput("rst_oe", 32'(uio_oe), 32'hFF);
        checkState("rst");
        rst_n = 1'b1;

        $display("[TB] sync timing");
        waitBit(7, 1'b0, 2000, t0, ok0);
        checkOutput("blank_rgb", 32'(uo_out & 8'h77), 32'd0);
        waitBit(7, 1'b1, 2000, t1, ok1);
        waitBit(7, 1'b0, 2000, t2, ok2);
        checkOutput("hs_edges_seen", 32'(ok0 & ok1 & ok2), 32'd1);
        checkOutput("hs_low", 32'(t1 - t0), 32'd96);
        checkOutput("hs_period", 32'(t2 - t0), 32'd800);
        waitBit(3, 1'b0, 900000, t0, ok0);
        waitBit(3, 1'b1, 900000, t1, ok1);
        waitBit(3, 1'b0, 900000, t2, ok2);
        checkOutput("vs_edges_seen", 32'(ok0 & ok1 & ok2), 32'd1);
        checkOutput("vs_low", 32'(t1 - t0), 32'd1600);
        checkOutput("vs_period", 32'(t2 - t0), 32'd420000);

        $display("[TB] mid-frame reset");
        hit_row = 1'b0;
        for (int i = 0; i < 450000 && !hit_row; i++) begin
            @(negedge clk);
            if (dut.v_count == 10'd200 && dut.h_count == 10'd300) hit_row = 1'b1;
        end
        checkOutput("row200_reached", 32'(hit_row), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_uo", 32'(uo_out), 32'h88);
        checkOutput("midrst_h", 32'(dut.h_count), 32'd0);
        checkOutput("midrst_v", 32'(dut.v_count), 32'd0);
        modelReset();
        checkState("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resume_h", 32'(dut.h_count), 32'd1);
        checkOutput("resume_v", 32'(dut.v_count), 32'd0);

        $display("[TB] crash into pipe");
        applyStimulus(8'h01, 240);
        checkState("crash");
        checkOutput("crash_flag", 32'(dut.game_over), 32'd1);
        applyStimulus(8'h02, 20);
        checkState("frozen");
        checkOutput("frozen_pipe", 32'(dut.pipe_x), 32'd174);
        checkPixel(165, 8, "px_bird");
        checkPixel(174, 8, "px_bird_over_pipe");
        checkPixel(200, 100, "px_pipe");
        checkPixel(600, 100, "px_over_bg");
        checkPixel(700, 100, "px_hblank");
        applyStimulus(8'h04, 1);
        checkState("restart");
        checkOutput("restart_bird", 32'(dut.bird_y), 32'd232);
        checkOutput("restart_pipe", 32'(dut.pipe_x), 32'd640);

        $display("[TB] down / up limits");
        applyStimulus(8'h02, 10);
        checkState("down10");
`ifndef FLAPPY_GRAVITY_EN
        checkOutput("down10_const", 32'(dut.bird_y), 32'd272);
`endif
        applyStimulus(8'h02, 90);
        checkState("down100");
        checkOutput("down100_clamp", 32'(dut.bird_y), 32'd464);
        applyStimulus(8'h04, 1);
        applyStimulus(8'h01, 70);
        checkState("up70");
        checkOutput("up70_clamp", 32'(dut.bird_y), 32'd0);

        $display("[TB] score through gap");
        applyStimulus(8'h04, 1);
        applyStimulus(8'h00, 300);
        checkState("score");
`ifndef FLAPPY_GRAVITY_EN
        checkOutput("score_const", 32'(uio_out), 32'd1);
`endif
        checkOutput("score_oe", 32'(uio_oe), 32'hFF);

        $display("[TB] random play");
        applyStimulus(8'h04, 1);
        for (int i = 0; i < 120; i++) begin
            ui = 8'($urandom);
            ui[2] = ($urandom_range(0, 15) == 0);
            applyStimulus(ui, int'($urandom_range(1, 8)));
            checkState("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
